mac_rx_framer: RTL and testbench
================================

MAC_RX_FRAMER -- requirements
Module: mac_rx_framer

Interface
REQ-001 Parameter P_MAX_FRAME, default 1522, maximum legal frame length in bytes (destination address through FCS).
REQ-002 Parameter P_MIN_FRAME, default 64, minimum legal frame length in bytes; used only under REQ-031.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 gmii_rx_dv  input  1  PHY receive data valid.
REQ-006 gmii_rx_er  input  1  PHY receive error.
REQ-007 gmii_rxd  input  8  PHY receive byte.
REQ-008 stream_out_startofpacket  output  1  first byte of frame.
REQ-009 stream_out_endofpacket  output  1  last byte of frame (last FCS byte).
REQ-010 stream_out_valid  output  1  data byte qualifier.
REQ-011 stream_out_data  output  8  frame byte, preamble and SFD removed.
REQ-012 stream_out_error  output  1  frame error; meaningful only on the endofpacket beat, 0 on all other beats.

Function
REQ-013 gmii_* inputs shall be registered once before any decode.
REQ-014 A byte sampled on gmii_rxd at edge k shall appear on stream_out_data after edge k+2; latency fixed, no backpressure.
REQ-015 FSM states: IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: dv=1 and byte 0x55 -> PREAMBLE; dv=1 and byte 0xD5 -> DATA; dv=1 and any other byte -> DROP; dv=0 -> stay.
REQ-017 PREAMBLE: 0x55 -> stay (no count limit); 0xD5 -> DATA; other byte with dv=1 -> DROP; dv=0 -> IDLE.
REQ-018 DATA: every byte with dv=1 is forwarded with valid=1; dv=0 -> IDLE.
REQ-019 DROP: no output; dv=0 -> IDLE.
REQ-020 Preamble and SFD bytes shall never appear on the output.
REQ-021 startofpacket=1 on the first byte after SFD only.
REQ-022 endofpacket=1 on the byte whose following sample has dv=0; one byte of lookahead is held internally for this.
REQ-023 One-byte frame: startofpacket and endofpacket both 1 on the same beat.
REQ-024 SFD followed directly by dv=0: no beat emitted.
REQ-025 valid is continuous from sop to eop; no gaps within a frame.
REQ-026 gmii_rx_er=1 on any sample while in DATA (SFD cycle included) shall set a sticky flag, reported as error=1 on the eop beat.
REQ-027 A 16-bit byte counter shall count forwarded bytes, saturating at 0xFFFF; count > P_MAX_FRAME shall give error=1 on eop; the frame is still forwarded in full.
REQ-028 Back-to-back frames with one dv=0 cycle between them shall both be delivered intact; counter and error flag clear at each SFD.

Reset
REQ-029 While rst_n=0: all outputs 0; state IDLE; counter 0; error flag 0; lookahead register invalid.
REQ-030 On the first sample after rst_n release with dv=1, the FSM shall enter DROP; partial frames are never emitted, and a frame truncated by reset produces no eop.

Configuration
REQ-031 Macro MAC_RX_RUNT_CHECK_EN defined: a frame with fewer than P_MIN_FRAME forwarded bytes gives error=1 on eop. Undefined: no minimum-length check and P_MIN_FRAME is unused; all other behaviour is identical.

Verification
REQ-032 Seven 0x55, one 0xD5, bytes 0x01..0x40, dv drops -> 64 beats, 0x01 with sop, 0x40 with eop, error=0, first beat two cycles after first data sample.
REQ-033 Same frame with rx_er=1 on byte 0x20 -> identical data, error=1 on eop beat only.
REQ-034 Preamble 0x55,0x55,0x12, then data, then dv low -> no output; next well-formed frame is delivered normally.
REQ-035 Two 64-byte frames separated by one dv=0 cycle -> two sop/eop pairs, no merged or missing bytes.
REQ-036 1600-byte frame -> 1600 beats, error=1 on eop. 20-byte frame -> error=1 with MAC_RX_RUNT_CHECK_EN defined, error=0 without it.
REQ-037 rst_n asserted mid-frame, then released while dv=1 -> outputs 0 immediately, no eop, remainder of the frame dropped, next frame delivered normally.

Source files
------------

// File: rtl/mac_rx_framer.sv
// mac_rx_framer: GMII receive framer; strips preamble/SFD and emits an Avalon-ST style byte stream.
// Optional feature macro: MAC_RX_RUNT_CHECK_EN (flag frames shorter than P_MIN_FRAME).
`default_nettype none

module mac_rx_framer #(
  parameter int P_MAX_FRAME = 1522,
  parameter int P_MIN_FRAME = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  input  logic [7:0] gmii_rxd,
  output logic       stream_out_startofpacket,
  output logic       stream_out_endofpacket,
  output logic       stream_out_valid,
  output logic [7:0] stream_out_data,
  output logic       stream_out_error
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

  localparam logic [7:0] C_PRE = 8'h55;
  localparam logic [7:0] C_SFD = 8'hD5;

  state_t      r_state;
  logic        r_dv;
  logic        r_er;
  logic [7:0]  r_rxd;
  logic        r_armed;
  logic        r_hold_vld;
  logic        r_hold_sop;
  logic [7:0]  r_hold_data;
  logic        r_first;
  logic        r_err;
  logic [15:0] r_cnt;

  logic w_more;
  logic w_long;
  logic w_runt;

  // A held byte is the last one unless the sample right behind it continues the frame.
  assign w_more = (r_state == S_DATA) && r_dv;
  assign w_long = {16'd0, r_cnt} > $unsigned(P_MAX_FRAME);

`ifdef MAC_RX_RUNT_CHECK_EN
  assign w_runt = {16'd0, r_cnt} < $unsigned(P_MIN_FRAME);
`else
  logic w_unused_min;
  assign w_unused_min = ^P_MIN_FRAME;
  assign w_runt = 1'b0;
`endif

  // Input register; r_armed stays low until the line has been seen idle after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dv    <= 1'b0;
      r_er    <= 1'b0;
      r_rxd   <= 8'd0;
      r_armed <= 1'b0;
    end else begin
      r_dv    <= gmii_rx_dv;
      r_er    <= gmii_rx_er;
      r_rxd   <= gmii_rxd;
      r_armed <= r_armed | ~gmii_rx_dv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_hold_vld  <= 1'b0;
      r_hold_sop  <= 1'b0;
      r_hold_data <= 8'd0;
      r_first     <= 1'b0;
      r_err       <= 1'b0;
      r_cnt       <= 16'd0;
    end else begin
      r_hold_vld <= 1'b0;
      case (r_state)
        S_IDLE, S_PREAMBLE: begin
          if (!r_dv) begin
            r_state <= S_IDLE;
          end else if (!r_armed) begin
            r_state <= S_DROP;
          end else if (r_rxd == C_PRE) begin
            r_state <= S_PREAMBLE;
          end else if (r_rxd == C_SFD) begin
            r_state <= S_DATA;
            r_first <= 1'b1;
            r_cnt   <= 16'd0;
            r_err   <= r_er;
          end else begin
            r_state <= S_DROP;
          end
        end
        S_DATA: begin
          if (!r_dv) begin
            r_state <= S_IDLE;
          end else begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= r_rxd;
            r_hold_sop  <= r_first;
            r_first     <= 1'b0;
            r_err       <= r_err | r_er;
            if (r_cnt != 16'hFFFF) begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        default: begin
          if (!r_dv) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stream_out_valid         <= 1'b0;
      stream_out_data          <= 8'd0;
      stream_out_startofpacket <= 1'b0;
      stream_out_endofpacket   <= 1'b0;
      stream_out_error         <= 1'b0;
    end else begin
      stream_out_valid         <= r_hold_vld;
      stream_out_data          <= r_hold_vld ? r_hold_data : 8'd0;
      stream_out_startofpacket <= r_hold_vld & r_hold_sop;
      stream_out_endofpacket   <= r_hold_vld & ~w_more;
      stream_out_error         <= r_hold_vld & ~w_more & (r_err | w_long | w_runt);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_rx_framer.sv
// tb_mac_rx_framer: table-driven frame vectors with a scoreboard of expected output beats.
`default_nettype none

module tb_mac_rx_framer;

  logic       clk;
  logic       rst_n;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic [7:0] gmii_rxd;
  logic       sop;
  logic       eop;
  logic       valid;
  logic [7:0] data;
  logic       err;

  mac_rx_framer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .gmii_rx_dv               (gmii_rx_dv),
    .gmii_rx_er               (gmii_rx_er),
    .gmii_rxd                 (gmii_rxd),
    .stream_out_startofpacket (sop),
    .stream_out_endofpacket   (eop),
    .stream_out_valid         (valid),
    .stream_out_data          (data),
    .stream_out_error         (err)
  );

`ifdef MAC_RX_RUNT_CHECK_EN
  localparam bit RUNT = 1'b1;
`else
  localparam bit RUNT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       err;
  } beat_t;

  typedef struct {
    int         pre_len;
    logic [7:0] bad;
    int         len;
    int         er_pos;
    int         gap;
    bit         deliver;
    bit         exp_err;
  } vec_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    first_drive_cyc = -1;
  int    last_sop_cyc = -1;
  bit    ignore = 1'b0;
  vec_t  vecs[11];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && !ignore) begin
      if (valid) begin
        beat_t got;
        got = '{d: data, sop: sop, eop: eop, err: err};
        if (sop) last_sop_cyc = cyc;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%02h sop=%0b eop=%0b err=%0b, required no beat", data, sop, eop, err);
        end else begin
          beat_t exp;
          exp = q.pop_front();
          if (got != exp) begin
            errors++;
            $display("FAIL beat: got data=%02h sop=%0b eop=%0b err=%0b, required data=%02h sop=%0b eop=%0b err=%0b",
                     got.d, got.sop, got.eop, got.err, exp.d, exp.sop, exp.eop, exp.err);
          end
        end
      end else if (sop || eop || err) begin
        checks++;
        errors++;
        $display("FAIL idle_flags: got sop=%0b eop=%0b err=%0b with valid=0, required 0", sop, eop, err);
      end
    end
  end

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(posedge clk);
    #1;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    gmii_rxd   = d;
  endtask

  task automatic send_frame(input vec_t v, input int seed);
    for (int i = 0; i < v.pre_len; i++) drive(1'b1, 1'b0, 8'h55);
    if (v.bad != 8'h00) drive(1'b1, 1'b0, v.bad);
    else                drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < v.len; i++) begin
      logic [7:0] b;
      b = 8'((i + 1 + seed) & 255);
      drive(1'b1, (i == v.er_pos), b);
      if (i == 0) first_drive_cyc = cyc;
      if (v.deliver)
        q.push_back('{d: b, sop: (i == 0), eop: (i == v.len - 1), err: (i == v.len - 1) ? v.exp_err : 1'b0});
    end
    for (int i = 0; i < v.gap; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 50 && q.size() != 0; t++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: %0d beats still pending, required 0", name, q.size());
    end
    q.delete();
  endtask

  initial begin
    //        pre  bad    len   er   gap deliver err
    vecs[0]  = '{7, 8'h00,   64, -1,  1, 1'b1, 1'b0};
    vecs[1]  = '{7, 8'h00,   64, 31,  4, 1'b1, 1'b1};
    vecs[2]  = '{2, 8'h12,   10, -1,  3, 1'b0, 1'b0};
    vecs[3]  = '{7, 8'h00,   64, -1,  1, 1'b1, 1'b0};
    vecs[4]  = '{1, 8'h00,    1, -1,  2, 1'b1, RUNT};
    vecs[5]  = '{0, 8'h00,   64, -1,  2, 1'b1, 1'b0};
    vecs[6]  = '{3, 8'h00,    0, -1,  2, 1'b0, 1'b0};
    vecs[7]  = '{7, 8'h00, 1600, -1,  3, 1'b1, 1'b1};
    vecs[8]  = '{7, 8'h00,   20, -1,  3, 1'b1, RUNT};
    vecs[9]  = '{7, 8'h00, 1522, -1,  1, 1'b1, 1'b0};
    vecs[10] = '{7, 8'h00, 1523, -1,  3, 1'b1, 1'b1};

    rst_n = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid, sop, eop, err, data} != 12'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %03h, required 000", {valid, sop, eop, err, data});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      send_frame(vecs[i], (i == 0 || i == 1 || i == 3) ? 0 : i * 17);
      if (i == 0) begin
        checks++;
        if (last_sop_cyc != first_drive_cyc + 3) begin
          errors++;
          $display("FAIL first_beat_latency: sop seen at cycle %0d, required %0d", last_sop_cyc, first_drive_cyc + 3);
        end
      end
    end
    drain("table");

    // Reset asserted mid-frame, released while dv is still high.
    ignore = 1'b1;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i + 8'hA0));
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, sop, eop, err, data} != 12'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %03h, required 000", {valid, sop, eop, err, data});
    end
    ignore = 1'b0;
    drive(1'b1, 1'b0, 8'hB0);
    drive(1'b1, 1'b0, 8'hB1);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'(i + 8'hC0));
    drive(1'b0, 1'b0, 8'h00);
    send_frame(vecs[0], 5);
    drive(1'b0, 1'b0, 8'h00);
    drain("after_reset");
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
